// File: rtl/pc_seq_pkg.sv
// Shared op encodings for the program-counter sequencer and its return stack.
// Pure definitions, no logic.
package pc_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses; push/pop take effect on the next edge, top is combinational.
// No backpressure: push when full and pop when empty are silently ignored.
module pc_ret_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    localparam int CW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [PC_W-1:0] stack_d [STACK_DEPTH];
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   top_idx;

    assign full    = (count_q == CW'(STACK_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign top_idx = count_q - CW'(1);

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!empty && top_idx == CW'(i)) begin
                top = stack_q[i];
            end
        end
    end

    always_comb begin
        stack_d = stack_q;
        count_d = count_q;
        if (push && !full) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (count_q == CW'(i)) begin
                    stack_d[i] = push_data;
                end
            end
            count_d = count_q + CW'(1);
        end else if (pop && !empty) begin
            // Zero the vacated slot so stale addresses never reappear on top.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (top_idx == CW'(i)) begin
                    stack_d[i] = '0;
                end
            end
            count_d = top_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with relative branches and CALL/RET; one-cycle update latency.
// No backpressure: pc_en is a strobe, every enabled op completes on the next edge.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int              PC_W        = 8,
    parameter int              INSTR_BYTES = 2,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    localparam int             CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    input  logic [OP_W-1:0] op,
    input  logic            cond,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] offset,
    input  logic            err_clr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ret_top,
    output logic [CW-1:0]   sp_count,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            ovf_err,
    output logic            unf_err
);

    logic [PC_W-1:0] pc_q, pc_d, seq;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            push, pop;

    pc_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq),
        .top       (ret_top),
        .count     (sp_count),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        seq   = pc_q + PC_W'(INSTR_BYTES);
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        // Clear first so a same-cycle set event overrides it.
        ovf_d = ovf_q & ~err_clr;
        unf_d = unf_q & ~err_clr;
        if (pc_en) begin
            pc_d = seq;
            case (op)
                OP_JUMP:   pc_d = target;
                OP_BRANCH: if (cond) pc_d = pc_q + offset;
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        pc_d = target;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = ret_top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign pc      = pc_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

    logic       clk;
    logic       rst;
    logic       pc_en;
    logic [2:0] op;
    logic       cond;
    logic [7:0] target;
    logic [7:0] offset;
    logic       err_clr;

    logic [7:0] pc0, top0, pc1, top1;
    logic [2:0] sp0;
    logic [0:0] sp1;
    logic       full0, empty0, ovf0, unf0;
    logic       full1, empty1, ovf1, unf1;

    int n_cmp = 0;
    int n_bad = 0;

    pc_seq dut0 (
        .clk(clk), .rst(rst), .pc_en(pc_en), .op(op), .cond(cond),
        .target(target), .offset(offset), .err_clr(err_clr),
        .pc(pc0), .ret_top(top0), .sp_count(sp0), .stack_full(full0),
        .stack_empty(empty0), .ovf_err(ovf0), .unf_err(unf0)
    );

    pc_seq #(.STACK_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .pc_en(pc_en), .op(op), .cond(cond),
        .target(target), .offset(offset), .err_clr(err_clr),
        .pc(pc1), .ret_top(top1), .sp_count(sp1), .stack_full(full1),
        .stack_empty(empty1), .ovf_err(ovf1), .unf_err(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: pc, return addresses in push order, entry count, flags.
    typedef struct packed {
        logic [7:0]      pc;
        logic [3:0][7:0] stk;
        int              cnt;
        bit              ovf;
        bit              unf;
    } mstate_t;

    mstate_t m0, m1;

    function automatic mstate_t mstep(mstate_t s, int depth, bit en, logic [2:0] o, bit c,
                                      logic [7:0] tgt, logic [7:0] off, bit clr);
        mstate_t    n   = s;
        logic [7:0] nxt = s.pc + 8'd2;
        if (clr) begin
            n.ovf = 1'b0;
            n.unf = 1'b0;
        end
        if (en) begin
            n.pc = nxt;
            if (o == 3'd1) n.pc = tgt;
            if (o == 3'd2 && c) n.pc = s.pc + off;
            if (o == 3'd3) begin
                if (s.cnt < depth) begin
                    n.stk[2'(s.cnt)] = nxt;
                    n.cnt = s.cnt + 1;
                    n.pc  = tgt;
                end else begin
                    n.ovf = 1'b1;
                end
            end
            if (o == 3'd4) begin
                if (s.cnt > 0) begin
                    n.pc = s.stk[2'(s.cnt - 1)];
                    n.stk[2'(s.cnt - 1)] = 8'h00;
                    n.cnt = s.cnt - 1;
                end else begin
                    n.unf = 1'b1;
                end
            end
        end
        return n;
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic cmp(string tag, mstate_t m, int depth, logic [7:0] a_pc, logic [7:0] a_top,
                       int a_sp, logic a_full, logic a_empty, logic a_ovf, logic a_unf);
        logic [7:0] e_top;
        e_top = (m.cnt > 0) ? m.stk[2'(m.cnt - 1)] : 8'h00;
        chk({tag, ".pc"},    32'(a_pc),    32'(m.pc));
        chk({tag, ".top"},   32'(a_top),   32'(e_top));
        chk({tag, ".sp"},    32'(a_sp),    32'(m.cnt));
        chk({tag, ".full"},  32'(a_full),  32'(m.cnt == depth));
        chk({tag, ".empty"}, 32'(a_empty), 32'(m.cnt == 0));
        chk({tag, ".ovf"},   32'(a_ovf),   32'(m.ovf));
        chk({tag, ".unf"},   32'(a_unf),   32'(m.unf));
    endtask

    task automatic cmp_both(string tag);
        cmp({tag, ".d0"}, m0, 4, pc0, top0, int'(sp0), full0, empty0, ovf0, unf0);
        cmp({tag, ".d1"}, m1, 1, pc1, top1, int'(sp1), full1, empty1, ovf1, unf1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m0 = mstep(m0, 4, pc_en, op, cond, target, offset, err_clr);
        m1 = mstep(m1, 1, pc_en, op, cond, target, offset, err_clr);
    endtask

    typedef struct {
        logic [2:0] op;
        bit         en;
        bit         cond;
        logic [7:0] tgt;
        logic [7:0] off;
        bit         clr;
        logic [7:0] e_pc;
        logic [7:0] e_top;
        int         e_sp;
        bit         e_ovf;
        bit         e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(logic [2:0] o, bit en, bit c, logic [7:0] tgt, logic [7:0] off, bit clr,
                       logic [7:0] e_pc, logic [7:0] e_top, int e_sp, bit e_ovf, bit e_unf);
        vec_t v;
        v.op = o; v.en = en; v.cond = c; v.tgt = tgt; v.off = off; v.clr = clr;
        v.e_pc = e_pc; v.e_top = e_top; v.e_sp = e_sp; v.e_ovf = e_ovf; v.e_unf = e_unf;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; pc_en = 1'b0; op = 3'd0; cond = 1'b0;
        target = 8'h00; offset = 8'h00; err_clr = 1'b0;
        m0 = '0; m1 = '0;

        // Expected dut0 behaviour (STACK_DEPTH=4, INSTR_BYTES=2) from reset.
        add(3'd0, 1, 0, 8'h00, 8'h00, 0, 8'h02, 8'h00, 0, 0, 0);
        add(3'd0, 1, 0, 8'h00, 8'h00, 0, 8'h04, 8'h00, 0, 0, 0);
        add(3'd0, 1, 0, 8'h00, 8'h00, 0, 8'h06, 8'h00, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(3'd1, 0, 0, 8'h55, 8'h00, 0, 8'h06, 8'h00, 0, 0, 0);
        add(3'd1, 1, 0, 8'hFE, 8'h00, 0, 8'hFE, 8'h00, 0, 0, 0);
        add(3'd0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
        add(3'd0, 1, 0, 8'h00, 8'h00, 0, 8'h02, 8'h00, 0, 0, 0);
        add(3'd2, 1, 1, 8'h00, 8'hFC, 0, 8'hFE, 8'h00, 0, 0, 0);
        add(3'd1, 1, 0, 8'h10, 8'h00, 0, 8'h10, 8'h00, 0, 0, 0);
        add(3'd2, 1, 1, 8'h00, 8'hF8, 0, 8'h08, 8'h00, 0, 0, 0);
        add(3'd1, 1, 0, 8'h10, 8'h00, 0, 8'h10, 8'h00, 0, 0, 0);
        add(3'd2, 1, 0, 8'h00, 8'hF8, 0, 8'h12, 8'h00, 0, 0, 0);
        add(3'd1, 1, 0, 8'h10, 8'h00, 0, 8'h10, 8'h00, 0, 0, 0);
        add(3'd3, 1, 0, 8'h40, 8'h00, 0, 8'h40, 8'h12, 1, 0, 0);
        add(3'd3, 1, 0, 8'h40, 8'h00, 0, 8'h40, 8'h42, 2, 0, 0);
        add(3'd3, 1, 0, 8'h40, 8'h00, 0, 8'h40, 8'h42, 3, 0, 0);
        add(3'd3, 1, 0, 8'h40, 8'h00, 0, 8'h40, 8'h42, 4, 0, 0);
        add(3'd3, 1, 0, 8'h40, 8'h00, 0, 8'h42, 8'h42, 4, 1, 0);
        add(3'd4, 1, 0, 8'h00, 8'h00, 0, 8'h42, 8'h42, 3, 1, 0);
        add(3'd4, 1, 0, 8'h00, 8'h00, 0, 8'h42, 8'h42, 2, 1, 0);
        add(3'd4, 1, 0, 8'h00, 8'h00, 0, 8'h42, 8'h12, 1, 1, 0);
        add(3'd4, 1, 0, 8'h00, 8'h00, 0, 8'h12, 8'h00, 0, 1, 0);
        add(3'd1, 1, 0, 8'h20, 8'h00, 0, 8'h20, 8'h00, 0, 1, 0);
        add(3'd4, 1, 0, 8'h00, 8'h00, 0, 8'h22, 8'h00, 0, 1, 1);
        add(3'd4, 1, 0, 8'h00, 8'h00, 1, 8'h24, 8'h00, 0, 0, 1);
        add(3'd4, 0, 0, 8'h00, 8'h00, 1, 8'h24, 8'h00, 0, 0, 0);
        add(3'd5, 1, 1, 8'h77, 8'h10, 0, 8'h26, 8'h00, 0, 0, 0);
        add(3'd7, 1, 1, 8'h77, 8'h10, 0, 8'h28, 8'h00, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset.pc", 32'(pc0), 32'h0);
        cmp_both("reset");
        rst = 1'b1;

        foreach (vecs[i]) begin
            op = vecs[i].op; pc_en = vecs[i].en; cond = vecs[i].cond;
            target = vecs[i].tgt; offset = vecs[i].off; err_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d.pc", i),  32'(pc0),  32'(vecs[i].e_pc));
            chk($sformatf("vec%0d.top", i), 32'(top0), 32'(vecs[i].e_top));
            chk($sformatf("vec%0d.sp", i),  32'(sp0),  32'(vecs[i].e_sp));
            chk($sformatf("vec%0d.full", i),  32'(full0),  32'(vecs[i].e_sp == 4));
            chk($sformatf("vec%0d.empty", i), 32'(empty0), 32'(vecs[i].e_sp == 0));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf0), 32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.unf", i), 32'(unf0), 32'(vecs[i].e_unf));
            cmp_both($sformatf("vec%0d", i));
        end

        // Two CALLs: depth-4 stack holds both, depth-1 stack overflows on the second.
        op = 3'd3; pc_en = 1'b1; target = 8'h60; err_clr = 1'b0;
        step();
        cmp_both("call1");
        step();
        cmp_both("call2");
        chk("call2.d1.ovf", 32'(ovf1), 32'h1);
        chk("call2.d0.sp", 32'(sp0), 32'h2);

        // Async reset between edges must act with no clock edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        m0 = '0; m1 = '0;
        chk("areset.d0.pc", 32'(pc0), 32'h0);
        chk("areset.d0.sp", 32'(sp0), 32'h0);
        chk("areset.d1.ovf", 32'(ovf1), 32'h0);
        cmp_both("areset");
        pc_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 600; k++) begin
            int r;
            pc_en   = ($urandom_range(0, 9) != 0);
            r       = int'($urandom_range(0, 9));
            op      = (r == 8) ? 3'd3 : (r == 9) ? 3'd4 : 3'(r);
            cond    = 1'($urandom_range(0, 1));
            target  = 8'($urandom_range(0, 255));
            offset  = 8'($urandom_range(0, 255));
            err_clr = ($urandom_range(0, 7) == 0);
            step();
            cmp_both($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
